rob_commit_ctrl: RTL and testbench

- In-order retirement sequencer that sits beside the ROB in the writeback stage.
- Inspects the ROB head each cycle and decides when the head may retire. Per instruction type it emits a register-file commit, a store-memory handshake, or a halt.
- Drives the ROB's commit_head input and keeps a retired-instruction counter for performance monitoring.

---
 rtl/rob_commit_ctrl.sv | 125 ++++++++++++
 tb/tb_rob_commit_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// In-order retirement sequencer beside the ROB: decides when the head may retire and
// emits a register-file commit, a store-memory handshake or a halt for each instruction.
module rob_commit_ctrl #(
  parameter int unsigned ROB_ADDR_SIZE  = 5,
  parameter int unsigned DEST_ADDR_SIZE = 4,
  parameter int unsigned INS_TYPE_SIZE  = 2,
  parameter int unsigned INS_STATE_SIZE = 1,
  parameter logic [INS_STATE_SIZE-1:0] FINISHED_STATE = INS_STATE_SIZE'(1),
  parameter int unsigned CNT_SIZE       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROB_ADDR_SIZE-1:0]  head_id,
  input  logic [ROB_ADDR_SIZE-1:0]  tail_id,
  input  logic                      is_full,
  input  logic [INS_STATE_SIZE-1:0] head_state,
  input  logic [DEST_ADDR_SIZE-1:0] head_dest_addr,
  input  logic [INS_TYPE_SIZE-1:0]  head_ins_type,
  input  logic                      commit_stall,
  input  logic                      st_ack,
  output logic                      commit_head,
  output logic                      rf_commit_en,
  output logic [DEST_ADDR_SIZE-1:0] rf_commit_addr,
  output logic [ROB_ADDR_SIZE-1:0]  commit_rob_id,
  output logic                      st_req,
  output logic                      halted,
  output logic [CNT_SIZE-1:0]       retired_count
);

  localparam logic [INS_TYPE_SIZE-1:0] TYPE_ALU    = INS_TYPE_SIZE'(0);
  localparam logic [INS_TYPE_SIZE-1:0] TYPE_STORE  = INS_TYPE_SIZE'(1);
  localparam logic [INS_TYPE_SIZE-1:0] TYPE_BRANCH = INS_TYPE_SIZE'(2);
  localparam logic [INS_TYPE_SIZE-1:0] TYPE_HALT   = INS_TYPE_SIZE'(3);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_n;
  logic                st_req_n;
  logic                halted_n;
  logic [CNT_SIZE-1:0] retired_count_n;
  logic                rob_empty;
  logic                head_ready;

  // A full ROB has head==tail but still holds an eligible head entry.
  assign rob_empty  = (head_id == tail_id) && !is_full;
  assign head_ready = !rob_empty && (head_state == FINISHED_STATE) && !commit_stall;

  assign commit_rob_id  = head_id;
  assign rf_commit_addr = head_dest_addr;

  // Next-state and same-cycle commit decode.
  always_comb begin
    state_n      = state;
    st_req_n     = st_req;
    halted_n     = halted;
    commit_head  = 1'b0;
    rf_commit_en = 1'b0;

    if (!reset) begin
      case (state)
        RUN: begin
          if (head_ready) begin
            if (head_ins_type == TYPE_ALU) begin
              commit_head  = 1'b1;
              rf_commit_en = 1'b1;
            end else if (head_ins_type == TYPE_BRANCH) begin
              commit_head = 1'b1;
            end else if (head_ins_type == TYPE_STORE) begin
              st_req_n = 1'b1;
              state_n  = ST_WAIT;
            end else if (head_ins_type == TYPE_HALT) begin
              commit_head = 1'b1;
              halted_n    = 1'b1;
              state_n     = HALTED;
            end
          end
        end
        // The store already owns the head; external stalls no longer apply.
        ST_WAIT: begin
          st_req_n = 1'b1;
          if (st_ack) begin
            commit_head = 1'b1;
            st_req_n    = 1'b0;
            state_n     = RUN;
          end
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: begin
          state_n  = RUN;
          st_req_n = 1'b0;
        end
      endcase
    end
  end

  // Saturating retirement counter for performance monitoring.
  always_comb begin
    retired_count_n = retired_count;
    if (commit_head && (retired_count != {CNT_SIZE{1'b1}})) begin
      retired_count_n = retired_count + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      st_req        <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_n;
      st_req        <= st_req_n;
      halted        <= halted_n;
      retired_count <= retired_count_n;
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl; a second instance with a 4-bit
// counter shares the stimulus to exercise counter saturation.
module tb_rob_commit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] head_id, tail_id;
  logic       is_full;
  logic [0:0] head_state;
  logic [3:0] head_dest_addr;
  logic [1:0] head_ins_type;
  logic       commit_stall, st_ack;

  logic        commit_head, rf_commit_en, st_req, halted;
  logic [3:0]  rf_commit_addr;
  logic [4:0]  commit_rob_id;
  logic [15:0] retired_count;

  logic        s_commit_head, s_rf_commit_en, s_st_req, s_halted;
  logic [3:0]  s_rf_commit_addr;
  logic [4:0]  s_commit_rob_id;
  logic [3:0]  s_retired_count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk(clk), .reset(reset), .head_id(head_id), .tail_id(tail_id), .is_full(is_full),
    .head_state(head_state), .head_dest_addr(head_dest_addr), .head_ins_type(head_ins_type),
    .commit_stall(commit_stall), .st_ack(st_ack), .commit_head(commit_head),
    .rf_commit_en(rf_commit_en), .rf_commit_addr(rf_commit_addr), .commit_rob_id(commit_rob_id),
    .st_req(st_req), .halted(halted), .retired_count(retired_count)
  );

  rob_commit_ctrl #(.CNT_SIZE(4)) dut_sat (
    .clk(clk), .reset(reset), .head_id(head_id), .tail_id(tail_id), .is_full(is_full),
    .head_state(head_state), .head_dest_addr(head_dest_addr), .head_ins_type(head_ins_type),
    .commit_stall(commit_stall), .st_ack(st_ack), .commit_head(s_commit_head),
    .rf_commit_en(s_rf_commit_en), .rf_commit_addr(s_rf_commit_addr),
    .commit_rob_id(s_commit_rob_id), .st_req(s_st_req), .halted(s_halted),
    .retired_count(s_retired_count)
  );

  task automatic set_head(input logic [4:0] h, input logic [4:0] t, input logic f,
                          input logic s, input logic [1:0] ty, input logic [3:0] d);
    head_id = h; tail_id = t; is_full = f; head_state = s; head_ins_type = ty; head_dest_addr = d;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; commit_stall = 1'b0; st_ack = 1'b0;
    set_head(5'd1, 5'd3, 1'b0, 1'b1, 2'd0, 4'd2);
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL reset_commit: got %b exp 0", commit_head); end
    tests++; if (rf_commit_en !== 1'b0) begin fails++; $display("FAIL reset_rf_en: got %b exp 0", rf_commit_en); end
    @(negedge clk); #1;
    tests++; if (st_req !== 1'b0) begin fails++; $display("FAIL reset_st_req: got %b exp 0", st_req); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b exp 0", halted); end
    tests++; if (retired_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", retired_count); end
    @(negedge clk);
    set_head(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic test_alu_stream;
    logic [3:0] dests [3];
    dests[0] = 4'd5; dests[1] = 4'd7; dests[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_head(5'(3 + i), 5'd6, 1'b0, 1'b1, 2'd0, dests[i]);
      #1;
      tests++; if (commit_head !== 1'b1) begin fails++; $display("FAIL alu_commit[%0d]: got %b exp 1", i, commit_head); end
      tests++; if (rf_commit_en !== 1'b1) begin fails++; $display("FAIL alu_rf_en[%0d]: got %b exp 1", i, rf_commit_en); end
      tests++; if (rf_commit_addr !== dests[i]) begin fails++; $display("FAIL alu_addr[%0d]: got %0d exp %0d", i, rf_commit_addr, dests[i]); end
      tests++; if (commit_rob_id !== 5'(3 + i)) begin fails++; $display("FAIL alu_rob_id[%0d]: got %0d exp %0d", i, commit_rob_id, 3 + i); end
      exp_cnt++;
    end
    @(negedge clk);
    set_head(5'd6, 5'd6, 1'b0, 1'b1, 2'd0, 4'd0);
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL alu_empty_after: got %b exp 0", commit_head); end
    tests++; if (retired_count !== 16'd3) begin fails++; $display("FAIL alu_count: got %0d exp 3", retired_count); end
  endtask

  task automatic test_empty_full;
    @(negedge clk);
    set_head(5'd4, 5'd4, 1'b0, 1'b1, 2'd0, 4'd1);
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL empty_commit: got %b exp 0", commit_head); end
    @(negedge clk);
    is_full = 1'b1;
    #1;
    tests++; if (commit_head !== 1'b1) begin fails++; $display("FAIL full_commit: got %b exp 1", commit_head); end
    exp_cnt++;
    @(negedge clk);
    set_head(5'd5, 5'd5, 1'b0, 1'b0, 2'd0, 4'd0);
    #1;
    tests++; if (retired_count !== exp_cnt) begin fails++; $display("FAIL full_count: got %0d exp %0d", retired_count, exp_cnt); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    set_head(5'd0, 5'd2, 1'b0, 1'b0, 2'd0, 4'd3);
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL not_finished: got %b exp 0", commit_head); end
    @(negedge clk);
    head_state = 1'b1; commit_stall = 1'b1;
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL stalled: got %b exp 0", commit_head); end
    @(negedge clk);
    commit_stall = 1'b0;
    #1;
    tests++; if (commit_head !== 1'b1) begin fails++; $display("FAIL stall_release: got %b exp 1", commit_head); end
    exp_cnt++;
    @(negedge clk);
    set_head(5'd1, 5'd1, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic run_store(input logic stall_in_wait, input string tag);
    int hi_cycles;
    hi_cycles = 0;
    @(negedge clk);
    st_ack = 1'b1;
    set_head(5'd10, 5'd12, 1'b0, 1'b0, 2'd1, 4'd0);
    #1;
    tests++; if (commit_head !== 1'b0 || st_req !== 1'b0) begin fails++; $display("FAIL %s_stray_ack: commit %b st_req %b exp 0 0", tag, commit_head, st_req); end
    @(negedge clk);
    st_ack = 1'b0; head_state = 1'b1;
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL %s_issue_commit: got %b exp 0", tag, commit_head); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      commit_stall = stall_in_wait;
      st_ack = (k == 3);
      #1;
      if (st_req === 1'b1) hi_cycles++;
      tests++; if (commit_head !== (k == 3)) begin fails++; $display("FAIL %s_wait_commit[%0d]: got %b exp %b", tag, k, commit_head, (k == 3)); end
    end
    tests++; if (commit_rob_id !== 5'd10) begin fails++; $display("FAIL %s_rob_id: got %0d exp 10", tag, commit_rob_id); end
    exp_cnt++;
    @(negedge clk);
    st_ack = 1'b0; commit_stall = 1'b0;
    set_head(5'd11, 5'd11, 1'b0, 1'b0, 2'd0, 4'd0);
    #1;
    if (st_req === 1'b1) hi_cycles++;
    tests++; if (hi_cycles != 4) begin fails++; $display("FAIL %s_st_req_len: got %0d exp 4", tag, hi_cycles); end
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL %s_after_ack: got %b exp 0", tag, commit_head); end
    tests++; if (retired_count !== exp_cnt) begin fails++; $display("FAIL %s_count: got %0d exp %0d", tag, retired_count, exp_cnt); end
  endtask

  task automatic test_store;
    run_store(1'b0, "store");
    run_store(1'b1, "store_stall");
  endtask

  task automatic test_halt;
    logic [1:0] types [4];
    logic       exp_c [4];
    logic       exp_rf [4];
    types[0] = 2'd0; types[1] = 2'd2; types[2] = 2'd3; types[3] = 2'd0;
    exp_c[0] = 1'b1; exp_c[1] = 1'b1; exp_c[2] = 1'b1; exp_c[3] = 1'b0;
    exp_rf[0] = 1'b1; exp_rf[1] = 1'b0; exp_rf[2] = 1'b0; exp_rf[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_head(5'(i), 5'd8, 1'b0, 1'b1, types[i], 4'd2);
      #1;
      tests++; if (commit_head !== exp_c[i]) begin fails++; $display("FAIL halt_commit[%0d]: got %b exp %b", i, commit_head, exp_c[i]); end
      tests++; if (rf_commit_en !== exp_rf[i]) begin fails++; $display("FAIL halt_rf_en[%0d]: got %b exp %b", i, rf_commit_en, exp_rf[i]); end
      tests++; if (halted !== (i == 3)) begin fails++; $display("FAIL halt_flag[%0d]: got %b exp %b", i, halted, (i == 3)); end
      if (exp_c[i]) exp_cnt++;
    end
    @(negedge clk); #1;
    tests++; if (commit_head !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL halt_hold: commit %b halted %b exp 0 1", commit_head, halted); end
    tests++; if (retired_count !== exp_cnt) begin fails++; $display("FAIL halt_count: got %0d exp %0d", retired_count, exp_cnt); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_reset: got %b exp 0", halted); end
    @(negedge clk);
    reset = 1'b0;
    set_head(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    exp_cnt = 16'd0;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_head(5'(28 + i), 5'(29 + i), 1'b0, 1'b1, 2'd0, 4'(i));
      #1;
      tests++; if (commit_head !== 1'b1) begin fails++; $display("FAIL sat_commit[%0d]: got %b exp 1", i, commit_head); end
      exp_cnt++;
    end
    @(negedge clk);
    set_head(5'd16, 5'd16, 1'b0, 1'b0, 2'd0, 4'd0);
    #1;
    tests++; if (retired_count !== exp_cnt) begin fails++; $display("FAIL sat_count16: got %0d exp %0d", retired_count, exp_cnt); end
    tests++; if (s_retired_count !== 4'd15) begin fails++; $display("FAIL sat_count4: got %0d exp 15", s_retired_count); end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    set_head(5'd10, 5'd12, 1'b0, 1'b1, 2'd1, 4'd0);
    @(negedge clk); #1;
    tests++; if (st_req !== 1'b1) begin fails++; $display("FAIL rst_wait_req: got %b exp 1", st_req); end
    @(negedge clk);
    reset = 1'b1; st_ack = 1'b1;
    #1;
    tests++; if (commit_head !== 1'b0) begin fails++; $display("FAIL rst_wait_commit: got %b exp 0", commit_head); end
    @(negedge clk);
    reset = 1'b0;
    set_head(5'd10, 5'd10, 1'b0, 1'b0, 2'd1, 4'd0);
    #1;
    tests++; if (st_req !== 1'b0) begin fails++; $display("FAIL rst_wait_drop: got %b exp 0", st_req); end
    tests++; if (retired_count !== 16'd0) begin fails++; $display("FAIL rst_wait_count: got %0d exp 0", retired_count); end
    @(negedge clk); #1;
    tests++; if (st_req !== 1'b0 || commit_head !== 1'b0) begin fails++; $display("FAIL rst_wait_abandon: st_req %b commit %b exp 0 0", st_req, commit_head); end
    st_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; commit_stall = 1'b0; st_ack = 1'b0; exp_cnt = 16'd0;
    set_head(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    test_reset;
    test_alu_stream;
    test_empty_full;
    test_stall;
    test_store;
    test_halt;
    test_saturation;
    test_reset_in_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
